// File: rtl/heap_shift_up_sequencer.sv
// heap_shift_up_sequencer: inserts a value into a heap array by shifting elements up one at a time.
// Ports: clock/reset (sync, active-high); req/array/pos/value/size request inputs;
// busy/done/error status; new_size/size_we size write-back; mem_addr/mem_re/mem_we/mem_wdata/mem_rdata
// single-port heap memory with 1-cycle read latency.
// Optional macro SHIFT_UP_SATURATE_EN: a full array accepts an insert, discarding its top element.
module heap_shift_up_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea = 4,
  parameter int NArrays = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req,
  input  logic [MemoryElementWidth-1:0] array,
  input  logic [MemoryElementWidth-1:0] pos,
  input  logic [MemoryElementWidth-1:0] value,
  input  logic [MemoryElementWidth-1:0] size,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [MemoryElementWidth-1:0] new_size,
  output logic                          size_we,
  output logic [MemoryElementWidth-1:0] mem_addr,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [MemoryElementWidth-1:0] mem_wdata,
  input  logic [MemoryElementWidth-1:0] mem_rdata
);
  localparam int W = MemoryElementWidth;
  localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_WRITE = 3'd2, S_INSERT = 3'd3, S_DONE = 3'd4;
  localparam logic [W-1:0] AREA = W'(NArea);
  localparam logic [W-1:0] ARRAYS = W'(NArrays);
  logic [2:0] state_q, state_d;
  logic [W-1:0] base_q, base_d, pos_q, pos_d, value_q, value_d, size_q, size_d, i_q, i_d;
  logic err_q, err_d;
  logic [W-1:0] i_start, i_dec, size_inc;
  logic bad_size, bad;
`ifdef SHIFT_UP_SATURATE_EN
  // A full array starts shifting from its last slot, so the top element falls off.
  assign bad_size = size > AREA;
  assign i_start  = (size == AREA) ? AREA - 1'b1 : size;
  assign size_inc = (size_q == AREA) ? AREA : size_q + 1'b1;
`else
  assign bad_size = size >= AREA;
  assign i_start  = size;
  assign size_inc = size_q + 1'b1;
`endif
  assign bad   = array >= ARRAYS || pos > size || pos >= AREA || bad_size;
  assign i_dec = i_q - 1'b1;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pos_d   = pos_q;
    value_d = value_q;
    size_d  = size_q;
    i_d     = i_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req) begin
        base_d  = array * AREA;
        pos_d   = pos;
        value_d = value;
        size_d  = size;
        i_d     = i_start;
        err_d   = bad;
        state_d = bad ? S_DONE : (i_start > pos ? S_READ : S_INSERT);
      end
      S_READ:   state_d = S_WRITE;
      S_WRITE: begin
        i_d     = i_dec;
        state_d = i_dec > pos_q ? S_READ : S_INSERT;
      end
      S_INSERT: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      pos_q   <= '0;
      value_q <= '0;
      size_q  <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pos_q   <= pos_d;
      value_q <= value_d;
      size_q  <= size_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  end
  // Outputs decode the registered state, so a reset clears every strobe on the next cycle.
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign error     = done & err_q;
  assign mem_re    = state_q == S_READ;
  assign mem_we    = state_q == S_WRITE || state_q == S_INSERT;
  assign size_we   = state_q == S_INSERT;
  assign new_size  = size_we ? size_inc : '0;
  assign mem_addr  = mem_re ? base_q + i_dec
                   : state_q == S_WRITE ? base_q + i_q
                   : size_we ? base_q + pos_q : '0;
  // The read issued in READ returns during WRITE and is forwarded straight to the next slot up.
  assign mem_wdata = state_q == S_WRITE ? mem_rdata : size_we ? value_q : '0;
endmodule

// File: doc/heap_shift_up_sequencer.md
Name: heap_shift_up_sequencer

Overview:
- Multi-cycle controller that performs the array "shiftUp" (insert at position) operation against a single-port, synchronous-read heap memory.
- Moves elements one at a time instead of copying the whole area in one combinational step.
- Sits between the instruction engine, which issues the request and owns arraySizes, and the heap memory port. It sequences reads and writes and returns the new array size.

Parameters:
- MemoryElementWidth, 12, width of heap elements, indices, sizes and addresses.
- NArea, 4, elements per array area; array base address = array*NArea.
- NArrays, 2, number of arrays; array >= NArrays is an error.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; sampled only when busy=0.
- array  in  MEW  target array number.
- pos  in  MEW  insertion index.
- value  in  MEW  value to insert.
- size  in  MEW  current arraySizes[array].
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- error  out  1  valid with done; 1 = request rejected, memory untouched.
- new_size  out  MEW  updated size; valid while size_we=1.
- size_we  out  1  one-cycle strobe to write new_size into arraySizes[array].
- mem_addr  out  MEW  heap address.
- mem_re  out  1  read strobe; mem_rdata is valid the following cycle.
- mem_we  out  1  write strobe.
- mem_wdata  out  MEW  write data.
- mem_rdata  in  MEW  read data, 1-cycle latency.

Behaviour:
- Reset: state=IDLE. busy, done, error, size_we, mem_re and mem_we = 0. new_size, mem_addr and mem_wdata = 0.
- States: IDLE, READ, WRITE, INSERT, DONE.
- Acceptance (cycle k): in IDLE with req=1, latch array, pos, value and size; base = array*NArea; i = size.
- Error check at acceptance (k+1 = DONE, error=1, no mem strobes, no size_we):
  - array >= NArrays;
  - pos > size;
  - pos >= NArea;
  - size >= NArea.
- Otherwise, at k+1 go to READ if i > pos, else to INSERT.
- READ: mem_addr = base+i-1, mem_re=1; next state WRITE.
- WRITE: mem_addr = base+i, mem_wdata = mem_rdata, mem_we=1; i = i-1; next state READ if i > pos, else INSERT.
- INSERT: mem_addr = base+pos, mem_wdata = value, mem_we=1, size_we=1, new_size = size+1; next state DONE.
- DONE: done=1 for one cycle, error as determined; next state IDLE. busy=0 from the cycle after DONE.
- Latency: n = size-pos moves take 2n cycles. INSERT occurs at k+1+2n and done at k+2+2n.
- Next request: the earliest acceptance is the cycle after DONE.
- req while busy=1 is ignored, not queued. Inputs may change freely after acceptance.
- Arithmetic: all values are unsigned MEW bits. Address computation never wraps for legal requests.
- Reset mid-operation: the next cycle is IDLE with all strobes 0.
  - No further memory or size writes occur.
  - Heap contents are left partially shifted and are not restored.
- Simultaneous reset and req: reset wins; the request is not accepted.

Optional Feature:
SHIFT_UP_SATURATE_EN
- Defined: size == NArea is legal, provided pos < NArea.
  - i starts at NArea-1, so the top element is discarded.
  - The remaining behaviour is unchanged.
  - new_size = NArea, i.e. min(size+1, NArea).
  - size > NArea remains an error.
- Undefined: size >= NArea is an error, as listed above.

Test Plan:
1. heap[4..6]=0,1,2; array=1, size=3, pos=2, value=99 -> heap[4..7]=0,1,99,2; new_size=4 with size_we at k+3; done at k+4; error=0.
2. array=0, size=0, pos=0, value=7 -> single write heap[0]=7 at k+1; new_size=1; done at k+2.
3. heap[0..2]=5,6,7; array=0, size=3, pos=0, value=9 -> heap[0..3]=9,5,6,7; 3 read/write pairs at k+1..k+6; done at k+8.
4. Full array: size=4, pos=1:
   - without the macro -> done+error at k+1, zero mem_we;
   - with SHIFT_UP_SATURATE_EN, heap[0..3]=1,2,3,4, value=8 -> 1,8,2,3; new_size=4.
5. Bad inputs: size=2, pos=3 -> error at k+1; array=2 -> error at k+1; heap unchanged; req held high during busy is not re-accepted until after DONE.
6. Reset mid-operation: reset asserted at k+3 of scenario 3 -> busy=0 and no strobes from k+4; then a fresh scenario 1 request completes correctly.
